if_prefetch_buffer: RTL

- Instruction-fetch front end that sits directly upstream of the xrv32i core.
- Generates sequential word addresses to the instruction memory and tolerates variable, in-order read latency.
- Buffers returned words with their PCs in a small FIFO and presents them to the core over a valid/ready handshake.
- Supports redirect (flush) from the core on taken branch/jump.

---
 rtl/if_prefetch_buffer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch buffer: issues sequential word fetches, tracks in-order responses and
// queues {instruction, PC} pairs for the core. Define IF_PREFETCH_BYPASS_EN for the empty-FIFO bypass.
module if_prefetch_buffer #(
   parameter int unsigned DEPTH           = 4,
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   output logic        mem_req_o,
   output logic [31:0] mem_addr_o,
   input  logic        mem_rvalid_i,
   input  logic [31:0] mem_rdata_i,
   output logic        inst_valid_o,
   output logic [31:0] inst_o,
   output logic [31:0] inst_pc_o,
   input  logic        inst_ready_i,
   input  logic        flush_i,
   input  logic [31:0] flush_pc_i,
   output logic        busy_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam int unsigned OW = $clog2(MAX_OUTSTANDING) + 1;
   // One extra bit so a flush can fold a full outstanding window onto a pending discard.
   localparam int unsigned DW = OW + 1;
   localparam int unsigned SW = CW + 1;

   localparam logic [OW-1:0] MAX_OUT = OW'(MAX_OUTSTANDING);
   localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

   logic [31:0]   fetch_pc_q;
   logic [31:0]   resp_pc_q;
   logic [CW-1:0] count_q;
   logic [AW-1:0] rd_ptr_q;
   logic [AW-1:0] wr_ptr_q;
   logic [OW-1:0] outstanding_q;
   logic [DW-1:0] discard_q;
   logic [31:0]   inst_hold_q;
   logic [31:0]   pc_hold_q;

   logic [31:0]   data_q [DEPTH];
   logic [31:0]   pc_q   [DEPTH];

   logic [31:0]   flush_tgt;
   logic [SW-1:0] occupancy;
   logic          resp_keep;
   logic          head_v;
   logic          bypass_v;
   logic          push;
   logic          pop;

   assign flush_tgt = flush_pc_i & 32'hFFFF_FFFC;
   assign occupancy = SW'(count_q) + SW'(outstanding_q);
   assign resp_keep = mem_rvalid_i && (discard_q == '0);
   assign head_v    = (count_q != '0);

   // Occupancy counts reads in flight so every returning word is guaranteed a slot.
   assign mem_req_o  = rst && !flush_i && (outstanding_q < MAX_OUT) && (occupancy < DEPTH_S);
   assign mem_addr_o = fetch_pc_q;

`ifdef IF_PREFETCH_BYPASS_EN
   assign bypass_v = rst && resp_keep && !head_v && !flush_i;
`else
   assign bypass_v = 1'b0;
`endif

   assign inst_valid_o = head_v || bypass_v;
   assign inst_o       = head_v ? data_q[rd_ptr_q] : (bypass_v ? mem_rdata_i : inst_hold_q);
   assign inst_pc_o    = head_v ? pc_q[rd_ptr_q]   : (bypass_v ? resp_pc_q   : pc_hold_q);

   assign pop    = head_v && inst_ready_i;
   assign push   = resp_keep && !flush_i && !(bypass_v && inst_ready_i);
   assign busy_o = (outstanding_q != '0) || (discard_q != '0);

   always_ff @(posedge clk) begin
      if (!rst) begin
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         count_q       <= '0;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         outstanding_q <= '0;
         discard_q     <= '0;
         inst_hold_q   <= '0;
         pc_hold_q     <= '0;
      end else begin
         if (inst_valid_o) begin
            inst_hold_q <= inst_o;
            pc_hold_q   <= inst_pc_o;
         end
         if (flush_i) begin
            fetch_pc_q    <= flush_tgt;
            resp_pc_q     <= flush_tgt;
            count_q       <= '0;
            rd_ptr_q      <= '0;
            wr_ptr_q      <= '0;
            outstanding_q <= '0;
            // Everything still in flight, less a response landing right now, becomes discard.
            discard_q     <= discard_q + DW'(outstanding_q) - DW'(mem_rvalid_i);
         end else begin
            if (mem_req_o) begin
               fetch_pc_q <= fetch_pc_q + 32'd4;
            end
            if (resp_keep) begin
               resp_pc_q <= resp_pc_q + 32'd4;
            end
            if (push) begin
               wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q       <= count_q + CW'(push) - CW'(pop);
            outstanding_q <= outstanding_q + OW'(mem_req_o) - OW'(resp_keep);
            if (mem_rvalid_i && (discard_q != '0)) begin
               discard_q <= discard_q - DW'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         data_q[wr_ptr_q] <= mem_rdata_i;
         pc_q[wr_ptr_q]   <= resp_pc_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst && mem_rvalid_i) begin
         assert ((outstanding_q != '0) || (discard_q != '0));
      end
   end

endmodule
